pht_rmw: RTL and testbench

- Parametrised next-generation pattern history table for the fetch-stage local-history predictor.
- Provides configurable depth and counter width, and a registered 1-cycle read port.
- Updates from the commit stage run as a pipelined read-modify-write, with forwarding into the read port.
- After reset, a self-sequencing init FSM writes every entry; no multi-port reset is needed.

---
 rtl/pht_rmw.sv | 131 +++++++++++++
 tb/tb_pht_rmw.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pht_rmw.sv
// Pattern history table: registered read port, two-stage RMW update with
// read forwarding, self-sequencing init sweep. Optional confidence output under PHT_CONF_EN.
module pht_rmw #(
  parameter int LOGINDEXSIZE = 12,
  parameter int INDEXSIZE    = 1 << LOGINDEXSIZE,
  parameter int SATCNTWIDTH  = 2,
  parameter int SATCNTINIT   = 1 << (SATCNTWIDTH-1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pht_rd_en_i,
  input  logic [LOGINDEXSIZE-1:0] pht_rd_index_i,
  input  logic [LOGINDEXSIZE-1:0] pht_wt_index_i,
  input  logic                    pht_cm_brdir_we_i,
  input  logic                    pht_cm_brdir_i,
  output logic                    pht_br_pred_o,
  output logic [SATCNTWIDTH-1:0]  pht_cnt_o,
  output logic                    pht_rd_valid_o,
  output logic                    pht_ready_o
`ifdef PHT_CONF_EN
  ,output logic                   pht_br_conf_o
`endif
);

  typedef logic [SATCNTWIDTH-1:0]  cnt_t;
  typedef logic [LOGINDEXSIZE-1:0] idx_t;
  typedef enum logic {INIT, RUN} state_e;

  localparam cnt_t CNT_MAX  = '1;
  localparam cnt_t CNT_INIT = cnt_t'(SATCNTINIT);

  function automatic cnt_t sat_step(input cnt_t c, input logic dir);
    if (dir) sat_step = (c == CNT_MAX) ? c : c + 1'b1;
    else     sat_step = (c == '0)      ? c : c - 1'b1;
  endfunction

  cnt_t   mem_q [INDEXSIZE];
  state_e state_q, state_d;
  idx_t   ptr_q, ptr_d;
  logic   u1_vld_q, u1_vld_d;
  idx_t   u1_idx_q, u1_idx_d;
  logic   u1_dir_q, u1_dir_d;
  logic   rd_vld_q, rd_vld_d;
  cnt_t   rd_cnt_q, rd_cnt_d;
  logic   conf_q, conf_d;

  logic   wr_en;
  idx_t   wr_idx;
  cnt_t   wr_cnt;
  cnt_t   u1_new;
  cnt_t   rd_sel;

  // U1 reads the array after any previous commit, so back-to-back updates chain without a bypass.
  assign u1_new = sat_step(mem_q[u1_idx_q], u1_dir_q);
  // A read sampled on the same edge that U1 commits to its index sees the new value.
  assign rd_sel = (u1_vld_q && (u1_idx_q == pht_rd_index_i)) ? u1_new : mem_q[pht_rd_index_i];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    u1_vld_d = 1'b0;
    u1_idx_d = u1_idx_q;
    u1_dir_d = u1_dir_q;
    rd_vld_d = 1'b0;
    rd_cnt_d = rd_cnt_q;
    conf_d   = conf_q;
    wr_en    = 1'b0;
    wr_idx   = u1_idx_q;
    wr_cnt   = u1_new;
    case (state_q)
      INIT: begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        wr_cnt = CNT_INIT;
        ptr_d  = ptr_q + 1'b1;
        if (&ptr_q) state_d = RUN;
      end
      default: begin
        wr_en = u1_vld_q;
        if (pht_cm_brdir_we_i) begin
          u1_vld_d = 1'b1;
          u1_idx_d = pht_wt_index_i;
          u1_dir_d = pht_cm_brdir_i;
        end
        if (pht_rd_en_i) begin
          rd_vld_d = 1'b1;
          rd_cnt_d = rd_sel;
          conf_d   = (rd_sel == '0) || (rd_sel == CNT_MAX);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INIT;
      ptr_q    <= '0;
      u1_vld_q <= 1'b0;
      u1_idx_q <= '0;
      u1_dir_q <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_cnt_q <= '0;
      conf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      u1_vld_q <= u1_vld_d;
      u1_idx_q <= u1_idx_d;
      u1_dir_q <= u1_dir_d;
      rd_vld_q <= rd_vld_d;
      rd_cnt_q <= rd_cnt_d;
      conf_q   <= conf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem_q[wr_idx] <= wr_cnt;
  end

  assign pht_cnt_o      = rd_cnt_q;
  assign pht_br_pred_o  = rd_cnt_q[SATCNTWIDTH-1];
  assign pht_rd_valid_o = rd_vld_q;
  assign pht_ready_o    = (state_q == RUN);
`ifdef PHT_CONF_EN
  assign pht_br_conf_o  = conf_q;
`else
  logic unused_conf;
  assign unused_conf = conf_q;
`endif

endmodule

// File: tb/tb_pht_rmw.sv
// Directed + random bench for pht_rmw against a table model where updates land one edge after acceptance.
module tb_pht_rmw;
  localparam int LIS = 4, W = 2, CINIT = 2, N = 16, CMAX = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         pht_rd_en_i = 1'b0;
  logic [LIS-1:0] pht_rd_index_i = '0;
  logic [LIS-1:0] pht_wt_index_i = '0;
  logic         pht_cm_brdir_we_i = 1'b0;
  logic         pht_cm_brdir_i = 1'b0;
  logic         pht_br_pred_o;
  logic [W-1:0] pht_cnt_o;
  logic         pht_rd_valid_o;
  logic         pht_ready_o;
`ifdef PHT_CONF_EN
  logic         pht_br_conf_o;
`endif

  pht_rmw #(.LOGINDEXSIZE(LIS), .SATCNTWIDTH(W), .SATCNTINIT(CINIT)) dut (
    .clock(clock), .reset(reset),
    .pht_rd_en_i(pht_rd_en_i), .pht_rd_index_i(pht_rd_index_i),
    .pht_wt_index_i(pht_wt_index_i), .pht_cm_brdir_we_i(pht_cm_brdir_we_i),
    .pht_cm_brdir_i(pht_cm_brdir_i), .pht_br_pred_o(pht_br_pred_o),
    .pht_cnt_o(pht_cnt_o), .pht_rd_valid_o(pht_rd_valid_o),
    .pht_ready_o(pht_ready_o)
`ifdef PHT_CONF_EN
    , .pht_br_conf_o(pht_br_conf_o)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state: table contents, update waiting to land, init progress, expected read outputs.
  int model [N];
  bit pend_v;
  int pend_idx;
  bit pend_dir;
  int init_edges;
  bit exp_vld;
  int exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int c, input bit dir);
    if (dir) return (c >= CMAX) ? CMAX : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic cyc(input bit ren, input int ridx, input bit we, input int widx, input bit dir);
    bit rdy_prev;
    pht_rd_en_i       = ren;
    pht_rd_index_i    = ridx[LIS-1:0];
    pht_cm_brdir_we_i = we;
    pht_wt_index_i    = widx[LIS-1:0];
    pht_cm_brdir_i    = dir;
    @(posedge clock);
    if (reset) begin
      init_edges = 0;
      pend_v = 0;
      exp_vld = 0;
      exp_cnt = 0;
      for (int i = 0; i < N; i++) model[i] = CINIT;
    end else begin
      rdy_prev = (init_edges == N);
      if (pend_v) model[pend_idx] = sat(model[pend_idx], pend_dir);
      pend_v = 0;
      exp_vld = 0;
      if (rdy_prev) begin
        if (ren) begin
          exp_vld = 1;
          exp_cnt = model[ridx];
        end
        if (we) begin
          pend_v = 1;
          pend_idx = widx;
          pend_dir = dir;
        end
      end else begin
        init_edges++;
      end
    end
    #1;
    chk("ready", pht_ready_o, init_edges == N);
    chk("valid", pht_rd_valid_o, exp_vld);
    chk("cnt", pht_cnt_o, exp_cnt);
    chk("pred", pht_br_pred_o, exp_cnt >= 2);
`ifdef PHT_CONF_EN
    chk("conf", pht_br_conf_o, (exp_cnt == 0) || (exp_cnt == CMAX));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    // Reset values, then the 16-cycle init sweep.
    do_reset();
    idle(15);
    chk("ready_low_16", pht_ready_o, 0);
    idle(1);
    chk("ready_high", pht_ready_o, 1);
    for (int i = 0; i < N; i++) cyc(1, i, 0, 0, 0);
    chk("init_last_cnt", pht_cnt_o, 2);

    // Saturation up and down on idx 5.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5, 1);
    cyc(1, 5, 0, 0, 0);
    chk("sat_up", pht_cnt_o, 3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 5, 0);
    cyc(1, 5, 0, 0, 0);
    chk("sat_down", pht_cnt_o, 0);
    chk("sat_down_pred", pht_br_pred_o, 0);
    cyc(0, 0, 1, 5, 0);
    idle(1);
    cyc(1, 5, 0, 0, 0);
    chk("sat_floor", pht_cnt_o, 0);
    idle(2);
    chk("hold_cnt", pht_cnt_o, 0);

    // Back-to-back updates to idx 7 with same-cycle and forwarded reads.
    cyc(1, 7, 1, 7, 1);
    chk("pre_update_read", pht_cnt_o, 2);
    cyc(0, 0, 1, 7, 1);
    cyc(1, 7, 0, 0, 0);
    chk("fwd_read", pht_cnt_o, 3);

    // Reset mid-init restarts the sweep; init-time update is dropped.
    do_reset();
    idle(9);
    do_reset();
    cyc(0, 0, 1, 3, 1);
    cyc(1, 3, 1, 3, 0);
    idle(13);
    chk("restart_ready_low", pht_ready_o, 0);
    idle(1);
    chk("restart_ready_high", pht_ready_o, 1);
    for (int i = 0; i < N; i++) cyc(1, i, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    chk("init_update_dropped", pht_cnt_o, 2);

    // Independent read and update ports.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 2, 1);
      chk("indep_rd", pht_cnt_o, 2);
    end
    cyc(1, 2, 0, 0, 0);
    chk("indep_upd", pht_cnt_o, 3);

`ifdef PHT_CONF_EN
    cyc(1, 0, 0, 0, 0);
    chk("conf_init", pht_br_conf_o, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0);
    chk("conf_sat_cnt", pht_cnt_o, 3);
    chk("conf_sat", pht_br_conf_o, 1);
`endif

    // Random traffic concentrated on few indices to exercise collisions.
    for (int i = 0; i < 400; i++) begin
      bit ren, we, dir;
      int ridx, widx;
      ren  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      ridx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : int'($urandom_range(0, 3));
      widx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N-1)) : int'($urandom_range(0, 3));
      cyc(ren, ridx, we, widx, dir);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
